// File: rtl/wb_regfile.sv
// Write-back select, 32x32 architectural register file and retired-write counter.
// Optional `WB_BYPASS_EN: same-cycle write-to-read bypass on both read ports.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned CNT_W  = 32,
  localparam int unsigned AddrW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemtoReg_WB,
  input  logic              RegWrite_WB,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [AddrW-1:0]  rd_in,
  input  logic [AddrW-1:0]  rs_addr,
  input  logic [AddrW-1:0]  rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en,
  output logic [CNT_W-1:0]  wb_count
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  count_q;

  always_comb begin
    wb_data = MemtoReg_WB ? data_in : alu_in;
    // Gate on RegWrite_WB first so X on rd_in during bubbles cannot raise the strobe.
    wb_en   = RegWrite_WB ? (rd_in != '0) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else if (wb_en) begin
      regs_q[rd_in] <= wb_data;
      count_q       <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : regs_q[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : regs_q[rt_addr];
`ifdef WB_BYPASS_EN
    // wb_en already excludes r0, so the bypass never disturbs reads of address 0.
    if (wb_en && (rs_addr == rd_in)) rs_data = wb_data;
    if (wb_en && (rt_addr == rd_in)) rt_data = wb_data;
`endif
  end

  assign wb_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: reference model plus expectation queue.
// Works for both builds; `WB_BYPASS_EN selects the expected same-cycle read behaviour.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemtoReg_WB, RegWrite_WB;
  logic [31:0] data_in, alu_in;
  logic [4:0]  rd_in, rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_en;
  logic [31:0] wb_count;

  // Narrow-counter copy shares all stimulus so its wrap is reachable quickly.
  logic [31:0] rs_data_s, rt_data_s, wb_data_s;
  logic        wb_en_s;
  logic [3:0]  wb_count_s;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];
  logic [31:0] model_cnt;
  logic [31:0] exp_q [$];
  logic [31:0] got, exp;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB),
    .data_in(data_in), .alu_in(alu_in), .rd_in(rd_in), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data), .wb_en(wb_en),
    .wb_count(wb_count)
  );

  wb_regfile #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB),
    .data_in(data_in), .alu_in(alu_in), .rd_in(rd_in), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data_s), .rt_data(rt_data_s), .wb_data(wb_data_s), .wb_en(wb_en_s),
    .wb_count(wb_count_s)
  );

  // Advance one rising edge, updating the reference model from the inputs presented.
  task automatic apply_edge();
    logic [31:0] v;
    v = MemtoReg_WB ? data_in : alu_in;
    @(posedge clk);
    if (reset === 1'b1) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      model_cnt = '0;
    end else if (RegWrite_WB === 1'b1 && rd_in != 5'd0) begin
      model[rd_in] = v;
      model_cnt    = model_cnt + 32'd1;
    end
    #1;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
`ifdef WB_BYPASS_EN
    if (RegWrite_WB === 1'b1 && rd_in == a) return MemtoReg_WB ? data_in : alu_in;
`endif
    return model[a];
  endfunction

  task automatic test_reset();
    reset = 1'b1; RegWrite_WB = 1'b0; MemtoReg_WB = 1'b0;
    data_in = '0; alu_in = '0; rd_in = '0; rs_addr = '0; rt_addr = '0;
    apply_edge();
    apply_edge();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      got = rs_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reset_rs[%0d] got %h want %h", i, got, exp);
      end
      got = rt_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reset_rt[%0d] got %h want %h", 31 - i, got, exp);
      end
    end
    checks++;
    if (wb_count !== 32'h0) begin
      errors++; $display("FAIL reset_count got %h want 0", wb_count);
    end
  endtask

  task automatic test_write_select();
    RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0;
    alu_in = 32'h1234_5678; data_in = 32'hDEAD_BEEF; rd_in = 5'd5;
    exp_q.push_back(32'h1234_5678);
    #1;
    got = wb_data; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sel_alu got %h want %h", got, exp); end
    checks++;
    if (wb_en !== 1'b1) begin errors++; $display("FAIL wb_en_r5 got %b want 1", wb_en); end
    apply_edge();
    RegWrite_WB = 1'b0; rs_addr = 5'd5;
    exp_q.push_back(32'h1234_5678);
    #1;
    got = rs_data; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL read_r5 got %h want %h", got, exp); end
    checks++;
    if (wb_count !== 32'd1) begin errors++; $display("FAIL count_1 got %h want 1", wb_count); end

    RegWrite_WB = 1'b1; MemtoReg_WB = 1'b1; rd_in = 5'd6;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    got = wb_data; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sel_mem got %h want %h", got, exp); end
    apply_edge();
    RegWrite_WB = 1'b0; rt_addr = 5'd6;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    got = rt_data; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL read_r6 got %h want %h", got, exp); end
    checks++;
    if (wb_count !== 32'd2) begin errors++; $display("FAIL count_2 got %h want 2", wb_count); end
  endtask

  task automatic test_r0();
    logic [31:0] cnt_before;
    cnt_before = model_cnt;
    RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0; alu_in = 32'hFFFF_FFFF; rd_in = 5'd0;
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    checks++;
    if (wb_en !== 1'b0) begin errors++; $display("FAIL r0_wb_en got %b want 0", wb_en); end
    checks++;
    if (rs_data !== 32'h0) begin errors++; $display("FAIL r0_bypass got %h want 0", rs_data); end
    apply_edge();
    RegWrite_WB = 1'b0;
    #1;
    checks++;
    if (rt_data !== 32'h0) begin errors++; $display("FAIL r0_read got %h want 0", rt_data); end
    checks++;
    if (wb_count !== cnt_before) begin
      errors++; $display("FAIL r0_count got %h want %h", wb_count, cnt_before);
    end
  endtask

  task automatic test_hazard();
    RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0; alu_in = 32'hA5A5_A5A5; rd_in = 5'd7;
    rs_addr = 5'd7; rt_addr = 5'd7;
`ifdef WB_BYPASS_EN
    exp_q.push_back(32'hA5A5_A5A5); exp_q.push_back(32'hA5A5_A5A5);
`else
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
`endif
    #1;
    got = rs_data; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL hazard_rs_pre got %h want %h", got, exp); end
    got = rt_data; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL hazard_rt_pre got %h want %h", got, exp); end
    apply_edge();
    RegWrite_WB = 1'b0;
    exp_q.push_back(32'hA5A5_A5A5); exp_q.push_back(32'hA5A5_A5A5);
    #1;
    got = rs_data; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL hazard_rs_post got %h want %h", got, exp); end
    got = rt_data; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL hazard_rt_post got %h want %h", got, exp); end
  endtask

  task automatic test_x_bubble();
    logic [31:0] cnt_before;
    cnt_before = model_cnt;
    RegWrite_WB = 1'b0; MemtoReg_WB = 1'bx; data_in = 'x; alu_in = 'x; rd_in = 'x;
    rs_addr = 5'd5; rt_addr = 5'd7;
    apply_edge();
    rd_in = 5'd0; MemtoReg_WB = 1'b0; data_in = '0; alu_in = '0;
    exp_q.push_back(32'h1234_5678); exp_q.push_back(32'hA5A5_A5A5);
    #1;
    got = rs_data; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL xbubble_r5 got %h want %h", got, exp); end
    got = rt_data; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL xbubble_r7 got %h want %h", got, exp); end
    checks++;
    if (wb_count !== cnt_before) begin
      errors++; $display("FAIL xbubble_count got %h want %h", wb_count, cnt_before);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      RegWrite_WB = ($urandom_range(0, 3) != 0);
      MemtoReg_WB = $urandom_range(0, 1) == 1;
      data_in = $urandom; alu_in = $urandom;
      rd_in = 5'($urandom_range(0, 31));
      rs_addr = (n % 3 == 0) ? rd_in : 5'($urandom_range(0, 31));
      rt_addr = 5'($urandom_range(0, 31));
      exp_q.push_back(exp_read(rs_addr)); exp_q.push_back(exp_read(rt_addr));
      #1;
      got = rs_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL b2b_rs[%0d] addr %0d got %h want %h", n, rs_addr, got, exp);
      end
      got = rt_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL b2b_rt[%0d] addr %0d got %h want %h", n, rt_addr, got, exp);
      end
      apply_edge();
    end
    RegWrite_WB = 1'b0;
    #1;
    checks++;
    if (wb_count !== model_cnt) begin
      errors++; $display("FAIL b2b_count got %h want %h", wb_count, model_cnt);
    end
  endtask

  task automatic test_reset_write();
    RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0; alu_in = 32'h99; rd_in = 5'd3;
    apply_edge();
    reset = 1'b1; alu_in = 32'h55;
    apply_edge();
    reset = 1'b0; RegWrite_WB = 1'b0; rs_addr = 5'd3; rt_addr = 5'd5;
    #1;
    checks++;
    if (rs_data !== 32'h0) begin errors++; $display("FAIL rstwr_r3 got %h want 0", rs_data); end
    checks++;
    if (rt_data !== 32'h0) begin errors++; $display("FAIL rstwr_r5 got %h want 0", rt_data); end
    checks++;
    if (wb_count !== 32'h0) begin errors++; $display("FAIL rstwr_count got %h want 0", wb_count); end
  endtask

  task automatic test_wrap();
    RegWrite_WB = 1'b1; MemtoReg_WB = 1'b0;
    for (int n = 0; n < 15; n++) begin
      rd_in = 5'(1 + n); alu_in = 32'(n);
      apply_edge();
    end
    RegWrite_WB = 1'b0;
    #1;
    checks++;
    if (wb_count_s !== 4'hF) begin errors++; $display("FAIL wrap_pre got %h want f", wb_count_s); end
    RegWrite_WB = 1'b1; rd_in = 5'd20; alu_in = 32'h77;
    apply_edge();
    RegWrite_WB = 1'b0;
    #1;
    checks++;
    if (wb_count_s !== 4'h0) begin errors++; $display("FAIL wrap_post got %h want 0", wb_count_s); end
    checks++;
    if (wb_count !== 32'd16) begin errors++; $display("FAIL wrap_wide got %h want 10", wb_count); end
  endtask

  initial begin
    model_cnt = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    test_reset();
    test_write_select();
    test_r0();
    test_hazard();
    test_x_bubble();
    test_back_to_back();
    test_reset_write();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
